// File: rtl/decode_imm_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate-select encoding, stage states
// and the opcode classifier used by the decode stage.
package core_pkg;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_t;

  typedef struct packed {
    imm_sel_t sel;
    logic     illegal;
  } imm_dec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // The opcode includes instr[1:0], so compressed encodings fall into the illegal default.
  function automatic imm_dec_t opcode_to_imm_sel(input logic [6:0] opcode);
    imm_dec_t dec;
    dec.sel     = IMM_NONE;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: dec.sel = IMM_I;
      OPC_STORE:            dec.sel = IMM_S;
      OPC_BRANCH:           dec.sel = IMM_B;
      OPC_LUI, OPC_AUIPC:   dec.sel = IMM_U;
      OPC_JAL:              dec.sel = IMM_J;
      OPC_OP:               dec.sel = IMM_NONE;
      default:              dec.illegal = 1'b1;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/decode_imm_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The stage is the slave; the surrounding pipeline (or bench) is the master.
interface decode_imm_stage_if
  import core_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_imm;
  imm_sel_t        out_imm_sel;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_sel, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_sel, out_illegal
  );
endinterface

// File: rtl/decode_imm_stage_immediate_gen.sv
// RV32I immediate generator: produces every sign-extended immediate format
// from instruction bits [31:7]; the caller selects the one it needs.
module immediate_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/decode_imm_stage.sv
// Registered decode-front stage: 2-entry skid buffer (OUT + SKID) between fetch and
// execute, immediate decode on the OUT-load path, flush and a drain counter.
module decode_imm_stage
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  decode_imm_stage_if.slave    bus,
  output logic [CNT_WIDTH-1:0] decode_count
);

  stage_state_t         state_q, state_d;
  logic [31:0]          out_instr_q, out_instr_d;
  logic [XLEN-1:0]      out_pc_q, out_pc_d;
  logic [31:0]          out_imm_q, out_imm_d;
  imm_sel_t             out_sel_q, out_sel_d;
  logic                 out_illegal_q, out_illegal_d;
  logic [31:0]          skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]      skid_pc_q, skid_pc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic            accept;
  logic            drain;
  logic            load_out;
  logic [31:0]     load_instr;
  logic [XLEN-1:0] load_pc;
  logic [31:0]     load_imm;
  imm_dec_t        load_dec;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;

  assign bus.in_ready    = (state_q != FULL);
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_instr   = out_instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_imm_sel = out_sel_q;
  assign bus.out_illegal = out_illegal_q;
  assign decode_count    = count_q;

  // A flushed cycle never takes the fetch word, even though in_ready still reflects state.
  assign accept = bus.in_valid & bus.in_ready & ~flush;
  assign drain  = bus.out_valid & bus.out_ready;

  // OUT is refilled from SKID only when FULL; otherwise straight from fetch.
  assign load_instr = (state_q == FULL) ? skid_instr_q : bus.in_instr;
  assign load_pc    = (state_q == FULL) ? skid_pc_q    : bus.in_pc;
  assign load_dec   = opcode_to_imm_sel(load_instr[6:0]);

  immediate_gen u_immediate_gen (
    .instr (load_instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    load_imm = '0;
    case (load_dec.sel)
      IMM_I:   load_imm = imm_i;
      IMM_S:   load_imm = imm_s;
      IMM_B:   load_imm = imm_b;
      IMM_U:   load_imm = imm_u;
      IMM_J:   load_imm = imm_j;
      default: load_imm = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    load_out     = 1'b0;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          skid_instr_d = bus.in_instr;
          skid_pc_d    = bus.in_pc;
          state_d      = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          load_out = 1'b1;
          state_d  = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    out_instr_d   = load_out ? load_instr       : out_instr_q;
    out_pc_d      = load_out ? load_pc          : out_pc_q;
    out_imm_d     = load_out ? load_imm         : out_imm_q;
    out_sel_d     = load_out ? load_dec.sel     : out_sel_q;
    out_illegal_d = load_out ? load_dec.illegal : out_illegal_q;

    // Drains count even in a flush cycle; the counter wraps naturally.
    count_d = drain ? count_q + CNT_WIDTH'(1) : count_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      out_sel_q     <= IMM_NONE;
      out_illegal_q <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_imm_q     <= out_imm_d;
      out_sel_q     <= out_sel_d;
      out_illegal_q <= out_illegal_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_decode_imm_stage.sv
// Scoreboard bench for decode_imm_stage: a FIFO reference model with arithmetic
// immediate decoding, directed scenarios followed by randomized traffic.
module tb_decode_imm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] decode_count;

  decode_imm_stage_if #(.XLEN(32)) dut_if ();

  decode_imm_stage #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (dut_if),
    .decode_count (decode_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        illegal;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] dir_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_count = 0;
  logic        prev_stall = 1'b0;
  exp_t        prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sign-extend the low 'bits' bits of v.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'h1 << (bits - 1);
    v = v & ((m << 1) - 32'h1);
    return (v ^ m) - m;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc = pc; e.instr = w; e.imm = 32'h0; e.sel = 3'd0; e.illegal = 1'b0;
    case (w & 32'h7F)
      32'h13, 32'h03, 32'h67, 32'h0F, 32'h73: begin
        e.sel = 3'd1; e.imm = sx(w >> 20, 12);
      end
      32'h23: begin
        e.sel = 3'd2; e.imm = sx(((w >> 25) << 5) | ((w >> 7) & 32'h1F), 12);
      end
      32'h63: begin
        e.sel = 3'd3;
        e.imm = sx((((w >> 31) & 32'h1) << 12) | (((w >> 7) & 32'h1) << 11) |
                   (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1), 13);
      end
      32'h37, 32'h17: begin
        e.sel = 3'd4; e.imm = w & 32'hFFFFF000;
      end
      32'h6F: begin
        e.sel = 3'd5;
        e.imm = sx((((w >> 31) & 32'h1) << 20) | (((w >> 12) & 32'hFF) << 12) |
                   (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1), 21);
      end
      32'h33: ;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 32'(dut_if.out_valid), 32'd0);
      check("rst_in_ready", 32'(dut_if.in_ready), 32'd1);
      check("rst_out_instr", dut_if.out_instr, 32'd0);
      check("rst_out_pc", dut_if.out_pc, 32'd0);
      check("rst_out_imm", dut_if.out_imm, 32'd0);
      check("rst_out_sel", 32'(dut_if.out_imm_sel), 32'd0);
      check("rst_out_illegal", 32'(dut_if.out_illegal), 32'd0);
      check("rst_count", decode_count, 32'd0);
      sb_q.delete();
      model_count = 0;
      prev_stall  = 1'b0;
    end else begin
      check("in_ready", 32'(dut_if.in_ready), 32'(sb_q.size() < 2));
      check("out_valid", 32'(dut_if.out_valid), 32'(sb_q.size() != 0));
      check("decode_count", decode_count, model_count);
      if (prev_stall) begin
        check("hold_instr", dut_if.out_instr, prev.instr);
        check("hold_pc", dut_if.out_pc, prev.pc);
        check("hold_imm", dut_if.out_imm, prev.imm);
      end
      prev_stall  = dut_if.out_valid && !dut_if.out_ready && !flush;
      prev.instr  = dut_if.out_instr;
      prev.pc     = dut_if.out_pc;
      prev.imm    = dut_if.out_imm;

      if (dut_if.out_valid && dut_if.out_ready && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", dut_if.out_pc, e.pc);
        check("sb_instr", dut_if.out_instr, e.instr);
        check("sb_imm", dut_if.out_imm, e.imm);
        check("sb_sel", 32'(dut_if.out_imm_sel), 32'(e.sel));
        check("sb_illegal", 32'(dut_if.out_illegal), 32'(e.illegal));
        if (dir_q.size() > 0) check("directed_imm", dut_if.out_imm, dir_q.pop_front());
        model_count = model_count + 32'd1;
      end
      if (dut_if.in_valid && dut_if.in_ready && !flush)
        sb_q.push_back(ref_decode(dut_if.in_pc, dut_if.in_instr));
      if (flush) sb_q.delete();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one word and return just after the edge that accepted it; in_valid stays up.
  task automatic send(input logic [31:0] pc, input logic [31:0] w);
    bit ok;
    int n;
    dut_if.in_valid = 1'b1;
    dut_if.in_pc    = pc;
    dut_if.in_instr = w;
    n = 0;
    do begin
      @(negedge clk);
      ok = dut_if.in_ready && !flush;
      cyc();
      n++;
    end while (!ok && n < 200);
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] fmt_words[4] = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h001000EF};
  logic [31:0] fmt_imms[4]  = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
  logic [31:0] bp_words[3]  = '{32'h00100093, 32'h00200113, 32'h00300193};
  logic [6:0]  opc_tab[14]  = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h33, 7'h00, 7'h7F, 7'h12};

  initial begin
    logic [31:0] saved;
    rst = 1'b1; flush = 1'b0;
    dut_if.in_valid = 1'b0; dut_if.in_instr = '0; dut_if.in_pc = '0; dut_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic ADDI -1
    dut_if.out_ready = 1'b1;
    dir_q.push_back(32'hFFFFFFFF);
    send(32'h100, 32'hFFF00093);
    dut_if.in_valid = 1'b0;
    check("addi_valid", 32'(dut_if.out_valid), 32'd1);
    check("addi_imm", dut_if.out_imm, 32'hFFFFFFFF);
    check("addi_sel", 32'(dut_if.out_imm_sel), 32'd1);
    check("addi_illegal", 32'(dut_if.out_illegal), 32'd0);
    check("addi_pc", dut_if.out_pc, 32'h100);
    cyc();
    check("addi_count", decode_count, 32'd1);

    // Back-to-back formats
    for (int i = 0; i < 4; i++) dir_q.push_back(fmt_imms[i]);
    for (int i = 0; i < 4; i++) send(32'h104 + 32'(4 * i), fmt_words[i]);
    dut_if.in_valid = 1'b0;
    repeat (3) cyc();
    check("formats_drained", 32'(dir_q.size()), 32'd0);
    check("formats_count", decode_count, 32'd5);

    // Backpressure: two accepted, FULL blocks the third until execute drains
    dut_if.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(32'h200 + 32'(4 * i), bp_words[i]);
        dut_if.in_valid = 1'b0;
      end
      begin
        repeat (4) cyc();
        check("bp_in_ready_full", 32'(dut_if.in_ready), 32'd0);
        check("bp_head", dut_if.out_instr, bp_words[0]);
        dut_if.out_ready = 1'b1;
      end
    join
    repeat (4) cyc();
    check("bp_count", decode_count, 32'd8);

    // Illegal words
    dir_q.push_back(32'h0);
    dir_q.push_back(32'h0);
    send(32'h300, 32'h00000000);
    check("illegal0_flag", 32'(dut_if.out_illegal), 32'd1);
    check("illegal0_sel", 32'(dut_if.out_imm_sel), 32'd0);
    send(32'h304, 32'h0000007F);
    dut_if.in_valid = 1'b0;
    check("illegal1_flag", 32'(dut_if.out_illegal), 32'd1);
    repeat (3) cyc();
    check("illegal_count", decode_count, 32'd10);

    // Flush from FULL with a word presented in the flush cycle
    dut_if.out_ready = 1'b0;
    send(32'h400, 32'h00500093);
    send(32'h404, 32'h00600093);
    saved = model_count;
    dut_if.in_pc = 32'h408; dut_if.in_instr = 32'h00700093;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    dut_if.in_valid = 1'b0;
    check("flush_out_valid", 32'(dut_if.out_valid), 32'd0);
    check("flush_in_ready", 32'(dut_if.in_ready), 32'd1);
    check("flush_count", decode_count, saved);
    dut_if.out_ready = 1'b1;
    repeat (3) cyc();
    check("flush_no_emit", decode_count, saved);

    // Reset while FULL
    dut_if.out_ready = 1'b0;
    send(32'h500, 32'h00800093);
    send(32'h504, 32'h00900093);
    dut_if.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_out_valid", 32'(dut_if.out_valid), 32'd0);
    check("midrst_count", decode_count, 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    dut_if.out_ready = 1'b1;
    send(32'h600, 32'hFFF00093);
    dut_if.in_valid = 1'b0;
    check("postrst_imm", dut_if.out_imm, 32'hFFFFFFFF);
    cyc();
    check("postrst_count", decode_count, 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = opc_tab[$urandom_range(0, 13)];
      dut_if.in_valid  = ($urandom_range(0, 9) < 7);
      dut_if.in_instr  = w;
      dut_if.in_pc     = $urandom & 32'hFFFFFFFC;
      dut_if.out_ready = ($urandom_range(0, 9) < 6);
      flush            = ($urandom_range(0, 31) == 0);
      cyc();
    end
    dut_if.in_valid = 1'b0; flush = 1'b0; dut_if.out_ready = 1'b1;
    repeat (5) cyc();
    check("final_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_imm_stage.md
Name: decode_imm_stage

Overview:
- Registered decode-front stage of the RV32I core, between fetch and execute.
- Accepts {pc, instruction} over a valid/ready handshake and buffers it in a 2-entry skid (output register + skid register).
- Classifies the opcode, selects the matching immediate from an immediate_gen instance, and presents {pc, instr, imm, imm_sel, illegal} to execute.
- Supports pipeline flush and keeps a retired-decode counter.

Parameters:
- XLEN, 32, datapath / PC width; only 32 is supported.
- CNT_WIDTH, 32, width of the decoded-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discards all buffered entries (branch/trap redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; equals (state != FULL).
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  PC of in_instr.
- out_valid  output  1  decoded entry available to execute.
- out_ready  input  1  execute accepts the entry.
- out_instr  output  32  instruction of the head entry.
- out_pc  output  XLEN  PC of the head entry.
- out_imm  output  32  selected, sign-extended immediate.
- out_imm_sel  output  3  imm_sel_t of the head entry.
- out_illegal  output  1  unsupported opcode, or instr[1:0] != 2'b11.
- decode_count  output  CNT_WIDTH  number of out handshakes since reset.

Behaviour:
- Reset (async):
  - state = EMPTY; out_valid = 0; out_instr/out_pc/out_imm = 0; out_imm_sel = IMM_NONE; out_illegal = 0; decode_count = 0.
  - in_ready = 1 while in reset.
- Events: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States and transitions (flush overrides every transition and goes to EMPTY):
  - EMPTY: accept -> load OUT, go to BUSY.
  - BUSY:
    - accept & drain -> reload OUT, stay in BUSY.
    - accept & !drain -> load SKID, go to FULL.
    - drain & !accept -> go to EMPTY.
  - FULL: in_ready = 0. drain -> move SKID into OUT, go to BUSY.
- Latency: an instruction accepted into EMPTY shows out_valid on the next cycle (1 cycle). No combinational path from in_* to out_*.
- Ordering: strict FIFO order. Outputs hold stable while out_valid & !out_ready.
- Immediate decode:
  - Computed combinationally from the word being loaded into OUT (input or SKID), then registered alongside it.
  - SKID stores the raw instruction only.
- Opcode to immediate select:
  - 0010011, 0000011, 1100111, 0001111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> NONE, imm = 0.
  - Any other opcode -> NONE, imm = 0, illegal = 1.
- Flush:
  - Both valids clear next cycle. An input presented in the flush cycle is not accepted; in_ready still reads per state that cycle, and fetch re-presents after the redirect.
  - Flush during a drain cycle: the drain still counts.
- decode_count:
  - Increments by 1 on every drain; wraps to 0 past all-ones.
  - Illegal entries count too. Unaffected by flush.
- rst asserted mid-operation discards everything immediately.

Decomposition:
- core_pkg holds:
  - OPC_* 7-bit opcode localparams.
  - imm_sel_t enum, 3 bits: IMM_NONE = 0, IMM_I = 1, IMM_S = 2, IMM_B = 3, IMM_U = 4, IMM_J = 5.
  - Function opcode_to_imm_sel returning {imm_sel_t, illegal}.
  - Stage state enum: EMPTY, BUSY, FULL.
- Sub-module: the existing immediate_gen, instantiated once on the OUT-load mux output (instruction[31:7]); a 6:1 mux on imm_sel picks its result.

Test Plan:
- Basic decode: reset, out_ready = 1, push 0xFFF00093 (ADDI -1) at pc 0x100 -> next cycle out_valid = 1, out_imm = 0xFFFFFFFF, sel = IMM_I, illegal = 0, decode_count = 1 after the drain.
- Back-to-back formats: push 0x0020A423 (SW 8), 0xFE000EE3 (BEQ -4), 0x123452B7 (LUI), 0x001000EF (JAL +2048) -> out_imm = 0x00000008 (S), 0xFFFFFFFC (B), 0x12345000 (U), 0x00000800 (J), one per cycle, in order.
- Backpressure: out_ready = 0, in_valid held with 3 words -> 2 accepted, in_ready = 0 in FULL. Raise out_ready -> all 3 emerge in order; the head is stable during the stall.
- Illegal: push 0x00000000 and 0x0000007F -> out_illegal = 1, imm = 0, sel = IMM_NONE; both still counted.
- Flush: in FULL, assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, the flush-cycle input is never emitted, decode_count unchanged.
- Reset mid-stream: assert rst while in FULL -> all outputs are 0 during reset; after release the first push decodes normally with count = 1.
